// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// No logic of its own; latency and backpressure are defined by muldiv_unit.
// Holds funct3 codes, FSM states and the operand signedness classes.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // How each operand is interpreted: both signed, rs1 signed / rs2 unsigned, both unsigned.
  typedef enum logic [1:0] {
    CLS_SS = 2'd0,
    CLS_SU = 2'd1,
    CLS_UU = 2'd2
  } cls_t;

  function automatic cls_t code_class(input logic [2:0] code);
    cls_t cls;
    case (code)
      MD_MULHSU:                  cls = CLS_SU;
      MD_MULHU, MD_DIVU, MD_REMU: cls = CLS_UU;
      default:                    cls = CLS_SS;
    endcase
    return cls;
  endfunction

  function automatic logic a_signed(input logic [2:0] code);
    return code_class(code) != CLS_UU;
  endfunction

  function automatic logic b_signed(input logic [2:0] code);
    return code_class(code) == CLS_SS;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: unsigned shift-add multiply or restoring radix-2 divide on magnitudes.
// One step per cycle while step is high; acc holds {hi, lo} product or {remainder, quotient}.
// No handshake of its own; the controlling FSM decides when to load and step.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN-1:0]          opnd;
  logic                     mode;
  logic [2*XLEN-1:0]        acc_next;
  logic [XLEN+MUL_BITS-1:0] mul_sum;
  logic [XLEN:0]            rem_sh;
  logic [XLEN-1:0]          rem_diff;

  // One iteration: add opnd x low multiplier digit then shift right, or shift left and trial-subtract.
  always_comb begin
    mul_sum  = (XLEN+MUL_BITS)'(acc[2*XLEN-1:XLEN])
             + (XLEN+MUL_BITS)'(opnd) * (XLEN+MUL_BITS)'(acc[MUL_BITS-1:0]);
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh[XLEN-1:0] - opnd;
    acc_next = acc;
    if (mode) begin
      if (rem_sh >= {1'b0, opnd}) begin
        acc_next = {rem_diff, acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:MUL_BITS]};
    end
  end

  // Load operands on accept (multiplier / dividend in the low half), then iterate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      opnd <= '0;
      mode <= 1'b0;
    end else if (load) begin
      mode <= div_mode;
      opnd <= div_mode ? mag_b : mag_a;
      acc  <= {{XLEN{1'b0}}, (div_mode ? mag_a : mag_b)};
    end else if (step) begin
      acc  <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit for EX: FSM, iteration count, special cases, sign fixup, reuse cache.
// Latency: XLEN/MUL_BITS+2 cycles for multiply, XLEN+2 for divide, 1 for special cases and reuse hits.
// Backpressure: md_stall_ex holds IF/ID/EX from accept until the DONE cycle; md_flush aborts at once.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_muldiv_ex,
  input  logic            cpu_stat_ex,
  input  logic [2:0]      md_code_ex,
  input  logic [XLEN-1:0] rs1_data_ex,
  input  logic [XLEN-1:0] rs2_data_ex,
  input  logic            md_flush,
  output logic            md_stall_ex,
  output logic            md_valid_ex,
  output logic [XLEN-1:0] md_result_ex
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN/MUL_BITS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  // MUL and REM take the low half; MULH*, DIV and DIVU the high half ({quotient, remainder}).
  function automatic logic [XLEN-1:0] pick(input logic [2:0] code, input logic [2*XLEN-1:0] val);
    logic low;
    low = (code == MD_MUL) || (code == MD_REM) || (code == MD_REMU);
    return low ? val[XLEN-1:0] : val[2*XLEN-1:XLEN];
  endfunction

  state_t            state, state_nxt;
  logic              accept, special, hit, last_iter;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] special_val, fix_val, acc;
  logic [XLEN-1:0]   quo, rem;
  logic [2:0]        code_q;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   rs1_q, rs2_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   result_q;

  logic              c_vld, c_div;
  cls_t              c_cls;
  logic [XLEN-1:0]   c_rs1, c_rs2;
  logic [2*XLEN-1:0] c_val;

  // Accept qualification, operand magnitudes and accept-cycle special cases.
  always_comb begin
    accept  = cmd_muldiv_ex & cpu_stat_ex & (state == IDLE) & ~md_flush;
    sign_a  = a_signed(md_code_ex) & rs1_data_ex[XLEN-1];
    sign_b  = b_signed(md_code_ex) & rs2_data_ex[XLEN-1];
    mag_a   = sign_a ? -rs1_data_ex : rs1_data_ex;
    mag_b   = sign_b ? -rs2_data_ex : rs2_data_ex;
    special = 1'b0;
    special_val = '0;
    if (md_code_ex[2]) begin
      if (rs2_data_ex == '0) begin
        special     = 1'b1;
        special_val = {{XLEN{1'b1}}, rs1_data_ex};
      end else if (code_class(md_code_ex) == CLS_SS && rs1_data_ex == MIN_NEG && rs2_data_ex == '1) begin
        special     = 1'b1;
        special_val = {rs1_data_ex, {XLEN{1'b0}}};
      end
    end
  end

  // Reuse lookup: MUL only needs a stored multiply; everything else needs the same class too.
  always_comb begin
    hit = 1'b0;
    if (REUSE_EN && c_vld && rs1_data_ex == c_rs1 && rs2_data_ex == c_rs2 && c_div == md_code_ex[2]) begin
      hit = (md_code_ex == MD_MUL) || (c_cls == code_class(md_code_ex));
    end
  end

  // Sign fixup of the magnitude result; divide results are repacked as {quotient, remainder}.
  always_comb begin
    quo = acc[XLEN-1:0];
    rem = acc[2*XLEN-1:XLEN];
    if (code_q[2]) begin
      fix_val = {((neg_a ^ neg_b) ? -quo : quo), (neg_a ? -rem : rem)};
    end else begin
      fix_val = (neg_a ^ neg_b) ? -acc : acc;
    end
  end

  assign last_iter = (cnt == (code_q[2] ? DIV_LAST : MUL_LAST));

  // Next state and handshake outputs; flush and reset override everything.
  always_comb begin
    state_nxt   = state;
    md_valid_ex = (state == DONE);
    md_stall_ex = ~rst & ~md_flush & (accept | (state == CALC) | (state == FIXUP));
    case (state)
      IDLE:    if (accept) state_nxt = (special || hit) ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (md_flush) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Command latch, iteration counter and registered result (zero outside DONE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q   <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        code_q <= md_code_ex;
        neg_a  <= sign_a;
        neg_b  <= sign_b;
        rs1_q  <= rs1_data_ex;
        rs2_q  <= rs2_data_ex;
      end
      if (accept)              cnt <= '0;
      else if (state == CALC)  cnt <= cnt + CNT_W'(1);
      if (accept && (special || hit))         result_q <= pick(md_code_ex, special ? special_val : c_val);
      else if (state == FIXUP && !md_flush)   result_q <= pick(code_q, fix_val);
      else                                    result_q <= '0;
    end
  end

  // Reuse cache: refreshed only by a computed (FIXUP) result that is not flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld <= 1'b0;
      c_div <= 1'b0;
      c_cls <= CLS_SS;
      c_rs1 <= '0;
      c_rs2 <= '0;
      c_val <= '0;
    end else if (REUSE_EN && state == FIXUP && !md_flush) begin
      c_vld <= 1'b1;
      c_div <= code_q[2];
      c_cls <= code_class(code_q);
      c_rs1 <= rs1_q;
      c_rs2 <= rs2_q;
      c_val <= fix_val;
    end
  end

  assign md_result_ex = result_q;

  muldiv_core #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (state == CALC),
    .div_mode (md_code_ex[2]),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .acc      (acc)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, MUL_BITS=2, REUSE_EN=1).
// Expected result and latency are queued when a command is driven and compared on md_valid_ex.
// Commands are held through the DONE cycle, as the EX stage would.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 18;
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd = 1'b0;
  logic        stat = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  code = 3'b000;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        md_stall;
  logic        md_valid;
  logic [31:0] md_result;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_BITS(2), .REUSE_EN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_muldiv_ex (cmd),
    .cpu_stat_ex   (stat),
    .md_code_ex    (code),
    .rs1_data_ex   (opa),
    .rs2_data_ex   (opb),
    .md_flush      (flush),
    .md_stall_ex   (md_stall),
    .md_valid_ex   (md_valid),
    .md_result_ex  (md_result)
  );

  // Reference RV32M semantics using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    longint     sx, sy, ux, uy;
    logic [63:0] pv;
    logic        ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    pv  = '0;
    case (c)
      3'd0: begin pv = sx * sy; return pv[31:0]; end
      3'd1: begin pv = sx * sy; return pv[63:32]; end
      3'd2: begin pv = sx * uy; return pv[63:32]; end
      3'd3: begin pv = ux * uy; return pv[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        pv = sx / sy; return pv[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        pv = ux / uy; return pv[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        pv = sx % sy; return pv[31:0];
      end
      default: begin
        if (y == 0) return x;
        pv = ux % uy; return pv[31:0];
      end
    endcase
  endfunction

  // Drive one command, hold it until DONE, then compare result, latency and stall profile.
  task automatic run_op(input string name, input logic [2:0] c, input logic [31:0] x,
                        input logic [31:0] y, input int lat, input bit gap);
    bit          done;
    bit          stall_ok;
    logic [31:0] er;
    int          el;
    @(negedge clk);
    code = c; opa = x; opb = y; cmd = 1'b1; stat = 1'b1;
    exp_res_q.push_back(model(c, x, y));
    exp_lat_q.push_back(lat);
    #1;
    checks++;
    if (md_stall !== 1'b1) $display("FAIL %s accept_stall got=%b want=1", name, md_stall);
    else passed++;
    done = 1'b0;
    stall_ok = 1'b1;
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      @(negedge clk);
      if (gap) stat = (cyc >= 3 && cyc <= 6) ? 1'b0 : 1'b1;
      #1;
      if (md_valid === 1'b1) begin
        done = 1'b1;
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        checks++;
        if (md_result !== er) $display("FAIL %s result got=%h want=%h", name, md_result, er);
        else passed++;
        checks++;
        if (cyc != el) $display("FAIL %s latency got=%0d want=%0d", name, cyc, el);
        else passed++;
        checks++;
        if (md_stall !== 1'b0) $display("FAIL %s done_stall got=%b want=0", name, md_stall);
        else passed++;
      end else if (md_stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    stat = 1'b1;
    if (!done) begin
      checks++;
      $display("FAIL %s timeout got=no_valid want=valid_at_%0d", name, lat);
      void'(exp_res_q.pop_front());
      void'(exp_lat_q.pop_front());
    end
    checks++;
    if (!stall_ok) $display("FAIL %s busy_stall got=low want=high_until_done", name);
    else passed++;
  endtask

  // Cycle after DONE: drop the command; a re-accept would show up as stall.
  task automatic idle(input string name);
    @(negedge clk);
    cmd = 1'b0;
    #1;
    checks++;
    if (md_valid !== 1'b0 || md_stall !== 1'b0 || md_result !== 32'h0)
      $display("FAIL %s idle got=v%b s%b r%h want=v0 s0 r0", name, md_valid, md_stall, md_result);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd = 1'b1; stat = 1'b1; code = MD_MUL; opa = 32'd3; opb = 32'd5;
    #2;
    checks++;
    if (md_stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", md_stall); else passed++;
    checks++;
    if (md_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", md_valid); else passed++;
    checks++;
    if (md_result !== 32'h0) $display("FAIL reset_result got=%h want=0", md_result); else passed++;
    @(negedge clk);
    cmd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op("mul_7x-3", MD_MUL, 32'd7, 32'hFFFF_FFFD, MUL_LAT, 1'b0);
    idle("mul_7x-3");
    run_op("mulhu_stat_gap", MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, MUL_LAT, 1'b1);
    idle("mulhu_stat_gap");
  endtask

  task automatic test_mul_reuse();
    run_op("mulh_min", MD_MULH, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 1'b0);
    idle("mulh_min");
    run_op("mul_hit", MD_MUL, 32'h8000_0000, 32'h8000_0000, 1, 1'b0);
    idle("mul_hit");
    run_op("mulhu_miss", MD_MULHU, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 1'b0);
    idle("mulhu_miss");
    run_op("mulhsu_miss", MD_MULHSU, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 1'b0);
    idle("mulhsu_miss");
  endtask

  task automatic test_div_reuse();
    run_op("div_-7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 1'b0);
    idle("div_-7/2");
    run_op("rem_hit", MD_REM, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
    idle("rem_hit");
    run_op("remu_miss", MD_REMU, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 1'b0);
    idle("remu_miss");
    run_op("divu_hit", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
    idle("divu_hit");
  endtask

  task automatic test_special();
    run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, 1, 1'b0);
    idle("divu_by0");
    run_op("remu_by0", MD_REMU, 32'd5, 32'd0, 1, 1'b0);
    idle("remu_by0");
    run_op("div_by0", MD_DIV, 32'hFFFF_FFF7, 32'd0, 1, 1'b0);
    idle("div_by0");
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    idle("div_ovf");
    run_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    idle("rem_ovf");
  endtask

  task automatic test_flush();
    bit seen;
    // Flush in the would-be accept cycle: nothing is accepted.
    @(negedge clk);
    code = MD_DIV; opa = 32'd1; opb = 32'd3; cmd = 1'b1; stat = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (md_stall !== 1'b0) $display("FAIL flush_accept_stall got=%b want=0", md_stall); else passed++;
    @(negedge clk);
    cmd = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (md_stall !== 1'b0 || md_valid !== 1'b0)
      $display("FAIL flush_no_accept got=s%b v%b want=s0 v0", md_stall, md_valid);
    else passed++;
    // Flush at cycle 10 of a divide.
    @(negedge clk);
    code = MD_DIV; opa = 32'd1000; opb = 32'd3; cmd = 1'b1;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (md_stall !== 1'b0) $display("FAIL flush_mid_stall got=%b want=0", md_stall); else passed++;
    @(negedge clk);
    flush = 1'b0; cmd = 1'b0;
    #1;
    checks++;
    if (md_stall !== 1'b0 || md_valid !== 1'b0)
      $display("FAIL flush_idle got=s%b v%b want=s0 v0", md_stall, md_valid);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (md_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL flush_no_valid got=valid want=none"); else passed++;
    run_op("divu_after_flush", MD_DIVU, 32'd100, 32'd7, DIV_LAT, 1'b0);
    idle("divu_after_flush");
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    code = MD_MULHU; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF; cmd = 1'b1; stat = 1'b1;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (md_stall !== 1'b0 || md_valid !== 1'b0 || md_result !== 32'h0)
      $display("FAIL rst_midop got=s%b v%b r%h want=s0 v0 r0", md_stall, md_valid, md_result);
    else passed++;
    @(negedge clk);
    cmd = 1'b0;
    rst = 1'b0;
    run_op("mulhu_ones", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
    idle("mulhu_ones");
    run_op("mul_ones_hit", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
    idle("mul_ones_hit");
    run_op("mulh_ones_miss", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
    idle("mulh_ones_miss");
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mul", MD_MUL, 32'd3, 32'd4, MUL_LAT, 1'b0);
    run_op("b2b_div", MD_DIV, 32'd100, 32'hFFFF_FFF9, DIV_LAT, 1'b0);
    run_op("b2b_rem_hit", MD_REM, 32'd100, 32'hFFFF_FFF9, 1, 1'b0);
    idle("b2b");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_mul_reuse();
    test_div_reuse();
    test_special();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
